// File: rtl/cross_bar_pkg.sv
// Shared crossbar sizing and the master index type used by per-slave arbiters.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cross_bar_pkg;

   localparam int MASTER_N = 4;
   localparam int SLAVE_N  = 4;

   typedef logic [$clog2(MASTER_N)-1:0] mst_idx_t;

endpackage : cross_bar_pkg

// File: rtl/rr_priority_select.sv
// Rotating-priority select: first set req bit at or after start_idx, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; sel_vld low when req is all-zero.
module rr_priority_select #(
   parameter int N = cross_bar_pkg::MASTER_N,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start_idx,
   output logic [N-1:0]  sel_onehot,
   output logic [IW-1:0] sel_idx,
   output logic          sel_vld
);

   // Walk N positions from start_idx; the first requester found wins.
   always_comb begin
      int pos;
      pos        = 0;
      sel_onehot = '0;
      sel_idx    = '0;
      sel_vld    = 1'b0;
      for (int off = 0; off < N; off++) begin
         pos = int'(start_idx) + off;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!sel_vld && req[pos[IW-1:0]]) begin
            sel_vld                 = 1'b1;
            sel_onehot[pos[IW-1:0]] = 1'b1;
            sel_idx                 = pos[IW-1:0];
         end
      end
   end

endmodule : rr_priority_select

// File: rtl/cross_bar_rr_arbiter.sv
// Round-robin arbiter for one crossbar slave port; registered one-hot grant with lock-on-hold.
// Latency: one cycle from request (or owner release) to grant change, no idle gap on handover.
// Backpressure: the owner holds the grant as long as its req stays high; others wait.
module cross_bar_rr_arbiter
   import cross_bar_pkg::*;
#(
   parameter int MASTER_N = cross_bar_pkg::MASTER_N
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic [MASTER_N-1:0] req,
   output logic [MASTER_N-1:0] grant
);

   localparam int IW = $clog2(MASTER_N);
   localparam logic [IW-1:0] LAST_RST = IW'(MASTER_N - 1);

   logic [MASTER_N-1:0] grant_q, grant_d;
   logic [IW-1:0]       last_q, last_d;
   logic [IW-1:0]       start_idx;
   logic [MASTER_N-1:0] sel_onehot;
   logic [IW-1:0]       sel_idx;
   logic                sel_vld;
   logic                hold;

   // Search begins one past the last winner, wrapping at MASTER_N.
   always_comb begin
      start_idx = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
   end

   rr_priority_select #(
      .N (MASTER_N)
   ) u_sel (
      .req        (req),
      .start_idx  (start_idx),
      .sel_onehot (sel_onehot),
      .sel_idx    (sel_idx),
      .sel_vld    (sel_vld)
   );

   // Grant is one-hot, so any overlap with req means the owner is still requesting.
   assign hold = |(grant_q & req);

   // Keep the owner while it requests; otherwise take the rotated winner (or go idle).
   always_comb begin
      grant_d = grant_q;
      last_d  = last_q;
      if (!hold) begin
         grant_d = sel_onehot;
         if (sel_vld) begin
            last_d = sel_idx;
         end
      end
   end

   // State registers; reset leaves master 0 with top priority.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         grant_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant = grant_q;

endmodule : cross_bar_rr_arbiter

// File: tb/tb_cross_bar_rr_arbiter.sv
// Directed bench for cross_bar_rr_arbiter with hand-computed grant sequences.
// Latency: checks grant #1 after each rising edge.
// Backpressure: exercises hold, handover, rotation, wrap and async reset.
module tb_cross_bar_rr_arbiter;

   logic       clk;
   logic       aresetn;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] req_at_edge;
   logic       mon_en;

   int n_cmp;
   int n_bad;

   cross_bar_rr_arbiter #(
      .MASTER_N (4)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .req     (req),
      .grant   (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got[3:0], exp[3:0], $time);
      end
   endtask

   // Apply a request vector, let one edge pass, then check the grant.
   task automatic step(input logic [3:0] r, input logic [3:0] exp_grant, input string tag);
      req = r;
      @(posedge clk);
      #1;
      check_eq(tag, {28'd0, grant}, {28'd0, exp_grant});
   endtask

   task automatic do_reset(input int cycles);
      aresetn = 1'b0;
      req     = 4'b0000;
      repeat (cycles) @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   // Capture req as seen by the DUT at each rising edge.
   always @(posedge clk) req_at_edge <= req;

   // Continuous invariants: grant one-hot or zero, and only to a master that requested.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
         check_eq("grant_implies_req", {28'd0, grant & ~req_at_edge}, 32'd0);
      end
   end

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      mon_en  = 1'b0;
      req     = 4'b0000;
      aresetn = 1'b0;
      #1;
      check_eq("reset_async_grant", {28'd0, grant}, 32'd0);

      // 1. Reset then idle
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i % 5 == 0) check_eq("reset_held", {28'd0, grant}, 32'd0);
      end
      aresetn = 1'b1;
      mon_en  = 1'b1;
      step(4'b0000, 4'b0000, "idle_after_release_0");
      step(4'b0000, 4'b0000, "idle_after_release_1");

      // 2. Single pulse
      step(4'b0001, 4'b0001, "pulse_grant");
      step(4'b0000, 4'b0000, "pulse_release");
      step(4'b0000, 4'b0000, "pulse_idle");

      // 3. Hold and handover (fresh pointer so master 0 is top priority)
      do_reset(2);
      step(4'b0011, 4'b0001, "hold_first");
      step(4'b0011, 4'b0001, "hold_keep_0");
      step(4'b0011, 4'b0001, "hold_keep_1");
      step(4'b0010, 4'b0010, "handover_no_gap");
      step(4'b0010, 4'b0010, "handover_hold");
      step(4'b0000, 4'b0000, "handover_idle");

      // 4. Rotation fairness
      do_reset(2);
      step(4'b1111, 4'b0001, "rot_m0");
      step(4'b1110, 4'b0010, "rot_m1");
      step(4'b1101, 4'b0100, "rot_m2");
      step(4'b1011, 4'b1000, "rot_m3");
      step(4'b0111, 4'b0001, "rot_wrap_m0");

      // 5. Skip and wrap
      step(4'b0000, 4'b0000, "skip_idle0");
      step(4'b0100, 4'b0100, "skip_set_last2");
      step(4'b0000, 4'b0000, "skip_idle_keeps_last");
      step(4'b0011, 4'b0001, "wrap_past_3");
      step(4'b0000, 4'b0000, "skip_idle1");
      step(4'b0101, 4'b0100, "skip_m1_to_m2");

      // 6. Async reset mid-grant
      req = 4'b0101;
      #3;
      aresetn = 1'b0;
      #1;
      check_eq("async_reset_clears", {28'd0, grant}, 32'd0);
      @(posedge clk);
      #1;
      check_eq("reset_held_over_edge", {28'd0, grant}, 32'd0);
      aresetn = 1'b1;
      step(4'b0101, 4'b0001, "post_reset_m0_priority");
      step(4'b0100, 4'b0100, "post_reset_handover");
      step(4'b0000, 4'b0000, "final_idle");

      mon_en = 1'b0;
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_cross_bar_rr_arbiter
